sbox_round_sequencer: RTL and testbench
=======================================

Name: sbox_round_sequencer

Overview:
- Time-multiplexed S-box substitution controller for the DES round function.
- Accepts one 48-bit post-expansion/XOR vector and steps a single shared S-box lookup resource through S1..S8, one 6-bit chunk per slot.
- Assembles the 32-bit substitution result and returns it through a valid/ready handshake to the P-permutation stage.
- Lets one lookup mux serve the whole round instead of eight parallel S-box instances.

Parameters:
NUM_SBOX, 8, number of S-boxes sequenced; input width 6*NUM_SBOX, output width 4*NUM_SBOX.
SBOX_LAT, 0, lookup latency in cycles of the external S-box resource; legal values 0..3.

Ports:
i_clk  input  1  clock; all state changes on the rising edge.
i_rst_n  input  1  synchronous active-low reset.
i_vector  input  6*NUM_SBOX  input vector; chunk k = i_vector[6*NUM_SBOX-1-6k -: 6], which feeds S-box k+1.
i_valid  input  1  i_vector valid.
o_in_ready  output  1  block can accept i_vector.
o_vector  output  4*NUM_SBOX  result; nibble k = o_vector[4*NUM_SBOX-1-4k -: 4].
o_valid  output  1  o_vector valid.
i_ready  input  1  downstream accepts o_vector.
o_sbox_sel  output  clog2(NUM_SBOX)  S-box index to the shared resource (0 = S1).
o_sbox_in  output  6  6-bit lookup address to the shared resource.
o_sbox_req  output  1  lookup active; sel/in are valid.
i_sbox_out  input  4  lookup result, valid SBOX_LAT cycles after sel/in are presented.
o_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (i_rst_n low at a rising edge):
  - Next state is IDLE; chunk counter k=0; wait counter=0.
  - Input capture register and result register are cleared to 0.
  - o_valid, o_sbox_req and o_busy are 0; o_sbox_sel and o_sbox_in are 0; o_vector is 0.
  - o_in_ready is forced 0 while i_rst_n is low.
- Reset mid-operation aborts the job; the partial result is discarded and no o_valid pulse is produced.
- States:
  - IDLE: o_in_ready=1. On i_valid & o_in_ready, capture i_vector, clear the result register, k=0, wait=0, go to LOOKUP.
  - LOOKUP:
    - Drive o_sbox_req=1, o_sbox_sel=k, o_sbox_in=chunk k from the captured copy.
    - If wait==SBOX_LAT: write i_sbox_out into nibble k and set wait=0. If k==NUM_SBOX-1, go to DONE; otherwise k=k+1.
    - Else: wait=wait+1.
    - sel and in are held stable for all SBOX_LAT+1 cycles of a slot.
  - DONE: o_valid=1; o_vector holds the result and stays stable while i_ready=0. On o_valid & i_ready, go to IDLE.
- o_in_ready=0 in LOOKUP and DONE. Acceptance never overlaps with output; there is at most one job in flight.
- Input changes after capture have no effect on the job.
- Latency:
  - o_valid rises NUM_SBOX*(SBOX_LAT+1) cycles after the accept edge.
  - Default is 8 cycles.
  - Next accept is possible no earlier than the cycle after the output handshake.
- o_vector is registered and is not modified outside LOOKUP writes; it keeps the last result through IDLE until the next accept clears it.
- Outputs in IDLE: o_sbox_req=0, sel/in=0.
- i_sbox_out is ignored outside the sampling cycle of each slot.
- i_valid held high while the block is busy is not accepted until IDLE; there is no buffering.
- Widths: k wraps only via the DONE transition and never exceeds NUM_SBOX-1. The wait counter is 2 bits.

Test Plan:
- Zero vector, SBOX_LAT=0, bench DES S-box model, i_ready=1: i_vector=48'h0 -> o_vector=32'hEFA72C4D, o_valid 8 cycles after accept, single-cycle pulse.
- All-ones vector: i_vector=48'hFFFFFFFFFFFF -> o_vector=32'hD9CE3DCB. Sequence check: o_sbox_sel steps 0..7 in order and o_sbox_in=6'h3F throughout.
- SBOX_LAT=2 build with the bench model delaying results by 2 cycles: i_vector=48'h0 -> result 32'hEFA72C4D at 24 cycles; sel/in stable for 3 cycles per slot.
- Backpressure: hold i_ready=0 for 10 cycles in DONE.
  - o_valid and o_vector stay stable and o_in_ready stays 0.
  - i_valid with a new vector is not accepted until the cycle after the handshake.
- Reset mid-job: assert i_rst_n=0 at k=4 -> after the edge, state IDLE, all outputs 0, no o_valid.
  - A new job then yields the correct result.
- Back-to-back jobs: 48'h0 then 48'hFFFFFFFFFFFF with i_valid held high -> outputs EFA72C4D then D9CE3DCB, in order, no loss or duplication.

Source files
------------

// File: rtl/sbox_round_sequencer.sv
// Time-multiplexed DES S-box sequencer: steps one shared lookup resource
// through S1..S(NUM_SBOX) and hands the assembled result to the P stage.
module sbox_round_sequencer #(
    parameter  int unsigned NUM_SBOX = 8,
    parameter  int unsigned SBOX_LAT = 0,
    localparam int unsigned SEL_W    = (NUM_SBOX > 1) ? $clog2(NUM_SBOX) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [6*NUM_SBOX-1:0] i_vector,
    input  logic                  i_valid,
    output logic                  o_in_ready,
    output logic [4*NUM_SBOX-1:0] o_vector,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [SEL_W-1:0]      o_sbox_sel,
    output logic [5:0]            o_sbox_in,
    output logic                  o_sbox_req,
    input  logic [3:0]            i_sbox_out,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      k_q, k_d;
    logic [1:0]            wait_q, wait_d;
    logic [6*NUM_SBOX-1:0] cap_q, cap_d;
    logic [4*NUM_SBOX-1:0] res_q, res_d;
    logic [5:0]            chunk;
    logic                  last_slot;
    logic                  sample;

    always_comb begin
        chunk = '0;
        for (int unsigned i = 0; i < NUM_SBOX; i++) begin
            if (k_q == SEL_W'(i)) begin
                chunk = cap_q[6*NUM_SBOX-1-6*i -: 6];
            end
        end
    end

    assign last_slot = (k_q == SEL_W'(NUM_SBOX - 1));
    assign sample    = (wait_q == 2'(SBOX_LAT));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wait_d  = wait_q;
        cap_d   = cap_q;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    cap_d   = i_vector;
                    res_d   = '0;
                    k_d     = '0;
                    wait_d  = '0;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (sample) begin
                    // only the addressed nibble takes the resource output
                    for (int unsigned i = 0; i < NUM_SBOX; i++) begin
                        if (k_q == SEL_W'(i)) begin
                            res_d[4*NUM_SBOX-1-4*i -: 4] = i_sbox_out;
                        end
                    end
                    wait_d = '0;
                    if (last_slot) begin
                        k_d     = '0;
                        state_d = DONE;
                    end else begin
                        k_d = k_q + SEL_W'(1);
                    end
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            wait_q  <= '0;
            cap_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
            cap_q   <= cap_d;
            res_q   <= res_d;
        end
    end

    // ready is gated by reset so nothing is offered while held in reset
    assign o_in_ready = (state_q == IDLE) && i_rst_n;
    assign o_valid    = (state_q == DONE);
    assign o_busy     = (state_q != IDLE);
    assign o_sbox_req = (state_q == LOOKUP);
    assign o_sbox_sel = (state_q == LOOKUP) ? k_q : '0;
    assign o_sbox_in  = (state_q == LOOKUP) ? chunk : '0;
    assign o_vector   = res_q;

endmodule

// File: tb/tb_sbox_round_sequencer.sv
// Bench for sbox_round_sequencer: DES S-box model behind a zero-latency
// and a two-cycle-latency instance, directed vectors and corner sequences.
module tb_sbox_round_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] vec    [2];
    logic        vld    [2];
    logic        rdy    [2];
    logic        in_rdy [2];
    logic [31:0] ovec   [2];
    logic        oval   [2];
    logic [2:0]  sel    [2];
    logic [5:0]  sin    [2];
    logic        req    [2];
    logic        busy   [2];
    logic [3:0]  sout0, sout2, dly1, dly2;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [47:0] vec;
        logic [31:0] exp;
        string       name;
    } vec_t;

    always #5 clk = ~clk;

    function automatic logic [3:0] des_sbox(input logic [2:0] s, input logic [5:0] a);
        logic [255:0] t;
        int unsigned  idx;
        case (s)
            3'd0: t = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
            3'd1: t = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
            3'd2: t = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
            3'd3: t = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
            3'd4: t = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
            3'd5: t = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
            3'd6: t = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
            default: t = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
        endcase
        idx = {26'd0, a[5], a[0], a[4:1]};
        return t[255 - 4*idx -: 4];
    endfunction

    function automatic logic [5:0] chunk_of(input logic [47:0] v, input int unsigned k);
        logic [47:0] t;
        t = v << (6 * k);
        return t[47:42];
    endfunction

    // shared resource models: combinational, and a two-stage delay line
    always_comb sout0 = des_sbox(sel[0], sin[0]);
    always_ff @(posedge clk) begin
        dly1 <= des_sbox(sel[1], sin[1]);
        dly2 <= dly1;
    end
    assign sout2 = dly2;

    sbox_round_sequencer #(.NUM_SBOX(8), .SBOX_LAT(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_vector(vec[0]), .i_valid(vld[0]),
        .o_in_ready(in_rdy[0]), .o_vector(ovec[0]), .o_valid(oval[0]),
        .i_ready(rdy[0]), .o_sbox_sel(sel[0]), .o_sbox_in(sin[0]),
        .o_sbox_req(req[0]), .i_sbox_out(sout0), .o_busy(busy[0])
    );

    sbox_round_sequencer #(.NUM_SBOX(8), .SBOX_LAT(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_vector(vec[1]), .i_valid(vld[1]),
        .o_in_ready(in_rdy[1]), .o_vector(ovec[1]), .o_valid(oval[1]),
        .i_ready(rdy[1]), .o_sbox_sel(sel[1]), .o_sbox_in(sin[1]),
        .o_sbox_req(req[1]), .i_sbox_out(sout2), .o_busy(busy[1])
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the accept edge.
    task automatic start_job(input int d, input logic [47:0] v, input string nm);
        vld[d] = 1'b1;
        vec[d] = v;
        check({nm, " in_ready idle"}, 64'(in_rdy[d]), 64'd1);
        tick();
        vld[d] = 1'b0;
        vec[d] = ~v;
    endtask

    task automatic wait_result(input int d, input logic [47:0] v, input logic [31:0] exp,
                               input string nm);
        int unsigned lat, cyc, slot;
        lat = (d == 0) ? 0 : 2;
        cyc = 0;
        while (!oval[d] && cyc < 200) begin
            if (cyc < 8 * (lat + 1)) begin
                slot = cyc / (lat + 1);
                check({nm, " seq"}, 64'({busy[d], req[d], in_rdy[d], sel[d], sin[d]}),
                      64'({1'b1, 1'b1, 1'b0, 3'(slot), chunk_of(v, slot)}));
            end
            tick();
            cyc++;
        end
        check({nm, " latency"}, 64'(cyc), 64'(8 * (lat + 1)));
        check({nm, " valid"}, 64'({oval[d], in_rdy[d], req[d]}), 64'b100);
        check({nm, " result"}, 64'(ovec[d]), 64'(exp));
    endtask

    task automatic finish_job(input int d, input logic [31:0] exp, input string nm);
        tick();
        check({nm, " pulse"}, 64'({oval[d], in_rdy[d], busy[d]}), 64'b010);
        check({nm, " hold idle"}, 64'(ovec[d]), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [5];
        int   pulses;
        tbl[0] = '{48'h000000000000, 32'hEFA72C4D, "zero"};
        tbl[1] = '{48'hFFFFFFFFFFFF, 32'hD9CE3DCB, "ones"};
        tbl[2] = '{48'h082082082082, 32'h410DC1B2, "row0col1"};
        tbl[3] = '{48'h861861861861, 32'hFD13B462, "row3col0"};
        tbl[4] = '{48'h001083105187, 32'hE30844E8, "ramp"};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vec[i] = '0;
            vld[i] = 1'b0;
            rdy[i] = 1'b1;
        end
        repeat (2) tick();
        for (int i = 0; i < 2; i++) begin
            check("reset outputs", 64'({in_rdy[i], oval[i], req[i], busy[i], sel[i], sin[i], ovec[i]}), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        check("ready after reset", 64'({in_rdy[0], in_rdy[1]}), 64'b11);
        tick();

        for (int i = 0; i < 5; i++) begin
            start_job(0, tbl[i].vec, tbl[i].name);
            wait_result(0, tbl[i].vec, tbl[i].exp, tbl[i].name);
            finish_job(0, tbl[i].exp, tbl[i].name);
        end

        // latency-2 instance
        start_job(1, 48'h0, "lat2 zero");
        wait_result(1, 48'h0, 32'hEFA72C4D, "lat2 zero");
        finish_job(1, 32'hEFA72C4D, "lat2 zero");
        start_job(1, 48'hFFFFFFFFFFFF, "lat2 ones");
        wait_result(1, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, "lat2 ones");
        finish_job(1, 32'hD9CE3DCB, "lat2 ones");

        // backpressure with a new job pending on the input
        rdy[0] = 1'b0;
        start_job(0, 48'h0, "bp");
        wait_result(0, 48'h0, 32'hEFA72C4D, "bp");
        vld[0] = 1'b1;
        vec[0] = 48'hFFFFFFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp hold", 64'({oval[0], in_rdy[0], ovec[0]}), 64'({1'b1, 1'b0, 32'hEFA72C4D}));
        end
        rdy[0] = 1'b1;
        tick();
        check("bp handshake", 64'({oval[0], in_rdy[0], busy[0], ovec[0]}),
              64'({1'b0, 1'b1, 1'b0, 32'hEFA72C4D}));
        tick();
        vld[0] = 1'b0;
        vec[0] = 48'h0;
        wait_result(0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, "bp next");
        finish_job(0, 32'hD9CE3DCB, "bp next");

        // back-to-back jobs with i_valid held high
        vld[0] = 1'b1;
        vec[0] = 48'h0;
        check("b2b in_ready", 64'(in_rdy[0]), 64'd1);
        tick();
        vec[0] = 48'hFFFFFFFFFFFF;
        wait_result(0, 48'h0, 32'hEFA72C4D, "b2b first");
        tick();
        check("b2b gap", 64'({oval[0], in_rdy[0]}), 64'b01);
        tick();
        vld[0] = 1'b0;
        wait_result(0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, "b2b second");
        finish_job(0, 32'hD9CE3DCB, "b2b second");

        // reset in the middle of a job, at slot 4
        start_job(0, 48'hFFFFFFFFFFFF, "rst");
        repeat (4) tick();
        check("rst at slot", 64'({req[0], sel[0]}), 64'({1'b1, 3'd4}));
        rst_n = 1'b0;
        #1;
        check("rst in_ready low", 64'(in_rdy[0]), 64'd0);
        @(posedge clk);
        #1;
        check("rst outputs", 64'({in_rdy[0], oval[0], req[0], busy[0], sel[0], sin[0], ovec[0]}), 64'd0);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (oval[0]) pulses++;
        end
        check("rst no valid", 64'(pulses), 64'd0);
        start_job(0, tbl[3].vec, "after rst");
        wait_result(0, tbl[3].vec, tbl[3].exp, "after rst");
        finish_job(0, tbl[3].exp, "after rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
